a2d_spi_resp: RTL and testbench
===============================

// Module: a2d_spi_resp
// PURPOSE
//  SPI responder that stands in for the 8-channel, 12-bit A2D converter on the A2D SPI bus.
//  Decodes the 16-bit command frames from the A2D interface master.
//  Returns the stored conversion value of the previously commanded channel on MISO in the next frame.
//  Used as the A2D model in system benches and as the responder in FPGA loop-back builds.
// PARAMETERS
//  CH_RST_VAL  12'h000  reset value of all 8 channel value registers
//  RAMP_STEP   12'h001  increment applied per completed read when A2D_RAMP_EN is defined
// PORTS
//  clk       in   1   system clock; must be >= 8x SCLK frequency
//  rst       in   1   reset; one clock; reset is synchronous and active-high
//  SS_n      in   1   SPI slave select, active low (asynchronous to clk)
//  SCLK      in   1   SPI clock, idles high (asynchronous to clk)
//  MOSI      in   1   SPI data from master
//  MISO      out  1   SPI data to master
//  ld_en     in   1   write ld_val into channel register ld_chnl this clk
//  ld_chnl   in   3   channel index for ld_en
//  ld_val    in   12  value to store
//  cmd_rdy   out  1   1-clk pulse: valid 16-bit frame received
//  cmd_chnl  out  3   channel from last valid frame (cmd bits [13:11])
//  frm_err   out  1   1-clk pulse: frame ended with bit count != 16
//  busy      out  1   high while a frame is in progress (synced SS_n low)
// BEHAVIOUR
//  - Synchronisation: SS_n, SCLK and MOSI each pass through 2 flops. SS_n and SCLK syncs reset to 1, MOSI to 0.
//  - Edges are detected with a third flop on SS_n and SCLK.
//  - Bit timing: the master changes MOSI on SCLK fall and samples MISO on SCLK rise.
//  - The responder samples MOSI on synced SCLK rise.
//  - The responder shifts its tx register left on synced SCLK fall, only when bit_cnt != 0.
//    This ignores the first fall after SS_n low.
//  - FSM states:
//    - IDLE: SS_n high.
//    - SHIFT: SS_n low.
//    - DONE: one clk after SS_n rise, then back to IDLE.
//  - IDLE -> SHIFT on synced SS_n fall:
//    - tx_shft <= {4'h0, ch_reg[cmd_chnl]}
//    - bit_cnt <= 0
//    - rx_shft unchanged
//  - SHIFT:
//    - Each SCLK rise: rx_shft <= {rx_shft[14:0], MOSI_sync}.
//    - Each SCLK rise: bit_cnt++, saturating at 31 (5 bits).
//    - SHIFT -> DONE on synced SS_n rise.
//  - DONE with bit_cnt == 16:
//    - cmd_chnl <= rx_shft[13:11]
//    - cmd_rdy = 1 for this clk
//    - other rx_shft bits are ignored
//  - DONE with bit_cnt != 16 (short, long or zero-length frame):
//    - frm_err = 1 for this clk
//    - cmd_chnl unchanged, no ramp
//  - MISO = tx_shft[15] while synced SS_n low, else 1'b0.
//  - Response latency is one frame:
//    - Frame N returns the channel commanded in frame N-1.
//    - The first frame after reset returns channel 0.
//  - ld_en writes ch_reg[ld_chnl] at the clk edge, in any state.
//    - tx_shft was already loaded at SS_n fall, so a write mid-frame affects the next frame only.
//  - SCLK edges while SS_n high are ignored.
//  - A SS_n rise and SCLK edge detected in the same clk: SS_n rise wins and the SCLK edge is dropped.
//  - Reset values:
//    - MISO=0, cmd_rdy=0, frm_err=0, cmd_chnl=0, busy=0
//    - FSM=IDLE, bit_cnt=0, tx_shft=0, rx_shft=0
//    - ch_reg[0..7]=CH_RST_VAL
//  - rst mid-frame: all of the above apply at once, and the frame in progress is discarded.
//    - If SS_n is still low when rst drops, the FSM waits in IDLE for the next SS_n fall.
// CONFIGURATION
//  - A2D_RAMP_EN defined: in DONE with cmd_rdy, the channel whose value was just transmitted is updated.
//    - ch_reg[that channel] <= ch_reg + RAMP_STEP, modulo 4096 (12'hFFF + 1 -> 12'h000).
//    - An ld_en to the same channel in the same clk wins over the ramp.
//  - A2D_RAMP_EN undefined: ch_reg changes only via ld_en or rst.
// TESTING
//  1. Load ch3=12'hABC via ld_en, then:
//     - frame cmd 16'h1800 -> cmd_rdy pulse, cmd_chnl=3, MISO returns 16'h0000.
//     - next frame cmd 16'h0000 -> MISO returns 16'h0ABC.
//  2. Load all channels with 12'h100*n + n and command channels 0..7 in sequence:
//     - each frame returns the previous channel's value.
//     - no frm_err is asserted.
//  3. Frame of 12 SCLKs -> frm_err pulse, no cmd_rdy, cmd_chnl unchanged; next 16-bit frame is accepted normally.
//  4. Assert rst after 8 SCLKs of a frame:
//     - all outputs are 0 and ch_reg returns to CH_RST_VAL.
//     - a following full frame for ch5 gives cmd_chnl=5.
//  5. With ch2 commanded in the previous frame, ld_en ch2=12'h555 mid-frame:
//     - the current frame still returns the old value.
//     - the next frame returns 12'h555.
//  6. With A2D_RAMP_EN defined, ch1=12'hFFF, two reads of ch1 -> returns 12'hFFF then 12'h000.

Source files
------------

// File: rtl/a2d_spi_resp.sv
// SPI responder modelling an 8-channel, 12-bit A2D converter on the A2D SPI bus.
// Optional feature: define A2D_RAMP_EN to auto-increment a channel after each successful read.
module a2d_spi_resp #(
  parameter logic [11:0] CH_RST_VAL = 12'h000,
  parameter logic [11:0] RAMP_STEP  = 12'h001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        ld_en,
  input  logic [2:0]  ld_chnl,
  input  logic [11:0] ld_val,
  output logic        cmd_rdy,
  output logic [2:0]  cmd_chnl,
  output logic        frm_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic        ss_ff1_q, ss_ff2_q, ss_ff3_q;
  logic        sclk_ff1_q, sclk_ff2_q, sclk_ff3_q;
  logic        mosi_ff1_q, mosi_ff2_q;
  logic [1:0]  settle_q;
  logic [4:0]  bit_cnt_q;
  logic [15:0] tx_shft_q;
  logic [15:0] rx_shft_q;
  logic [2:0]  cmd_chnl_q;
  logic [11:0] ch_reg_q [8];

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic load_tx, rx_en, tx_en;
  logic unused_rx;

  always_ff @(posedge clk) begin
    if (rst) begin
      {ss_ff3_q, ss_ff2_q, ss_ff1_q}       <= 3'b111;
      {sclk_ff3_q, sclk_ff2_q, sclk_ff1_q} <= 3'b111;
      {mosi_ff2_q, mosi_ff1_q}             <= 2'b00;
      settle_q                             <= 2'd0;
    end else begin
      {ss_ff3_q, ss_ff2_q, ss_ff1_q}       <= {ss_ff2_q, ss_ff1_q, SS_n};
      {sclk_ff3_q, sclk_ff2_q, sclk_ff1_q} <= {sclk_ff2_q, sclk_ff1_q, SCLK};
      {mosi_ff2_q, mosi_ff1_q}             <= {mosi_ff1_q, MOSI};
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  // The synchronisers restart at 1 after reset, so a slave select that is
  // already low would look like a fresh fall; wait until the whole chain
  // holds real input before trusting a falling edge.
  assign ss_fall   = ss_ff3_q & ~ss_ff2_q & (settle_q == 2'd3);
  assign ss_rise   = ~ss_ff3_q & ss_ff2_q;
  assign sclk_rise = ~sclk_ff3_q & sclk_ff2_q;
  assign sclk_fall = sclk_ff3_q & ~sclk_ff2_q;

  always_comb begin
    state_d = state_q;
    load_tx = 1'b0;
    rx_en   = 1'b0;
    tx_en   = 1'b0;
    cmd_rdy = 1'b0;
    frm_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = SHIFT;
          load_tx = 1'b1;
        end
      end
      SHIFT: begin
        // A slave-select rise drops any SCLK edge seen in the same clock.
        if (ss_rise) begin
          state_d = DONE;
        end else begin
          rx_en = sclk_rise;
          tx_en = sclk_fall && (bit_cnt_q != 5'd0);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (bit_cnt_q == 5'd16) cmd_rdy = 1'b1;
        else                    frm_err = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 5'd0;
      tx_shft_q  <= 16'h0000;
      rx_shft_q  <= 16'h0000;
      cmd_chnl_q <= 3'd0;
    end else begin
      state_q <= state_d;
      if (load_tx) begin
        tx_shft_q <= {4'h0, ch_reg_q[cmd_chnl_q]};
        bit_cnt_q <= 5'd0;
      end
      if (rx_en) begin
        rx_shft_q <= {rx_shft_q[14:0], mosi_ff2_q};
        if (bit_cnt_q != 5'd31) bit_cnt_q <= bit_cnt_q + 5'd1;
      end
      if (tx_en) tx_shft_q <= {tx_shft_q[14:0], 1'b0};
      if (cmd_rdy) cmd_chnl_q <= rx_shft_q[13:11];
    end
  end

  // cmd_chnl_q still names the channel just transmitted while in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) ch_reg_q[i] <= CH_RST_VAL;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (ld_en && (ld_chnl == 3'(i))) begin
          ch_reg_q[i] <= ld_val;
        end
`ifdef A2D_RAMP_EN
        else if (cmd_rdy && (cmd_chnl_q == 3'(i))) begin
          ch_reg_q[i] <= ch_reg_q[i] + RAMP_STEP;
        end
`endif
      end
    end
  end

`ifndef A2D_RAMP_EN
  logic unused_ramp;
  assign unused_ramp = ^RAMP_STEP;
`endif

  assign unused_rx = rx_shft_q[15];
  assign MISO      = ~ss_ff2_q & tx_shft_q[15];
  assign cmd_chnl  = cmd_chnl_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Self-checking bench for a2d_spi_resp: directed scenarios plus randomized frames
// checked against a channel-array model of the converter.
module tb_a2d_spi_resp;

  localparam logic [11:0] RST_VAL = 12'h000;
  localparam logic [11:0] STEP    = 12'h001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_chnl = 3'd0;
  logic [11:0] ld_val = 12'h000;
  logic        MISO, cmd_rdy, frm_err, busy;
  logic [2:0]  cmd_chnl;

  a2d_spi_resp #(.CH_RST_VAL(RST_VAL), .RAMP_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ld_en(ld_en), .ld_chnl(ld_chnl), .ld_val(ld_val),
    .cmd_rdy(cmd_rdy), .cmd_chnl(cmd_chnl), .frm_err(frm_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_cnt  = 0;
  int err_cnt  = 0;

  always @(negedge clk) begin
    if (cmd_rdy === 1'b1) rdy_cnt++;
    if (frm_err === 1'b1) err_cnt++;
  end

  // Reference model: channel values and the channel named by the last good frame.
  logic [11:0] m_ch [8];
  logic [2:0]  m_chnl;
  logic [3:0]  snap_bus;
  logic [2:0]  snap_chnl;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_ch[i] = RST_VAL;
    m_chnl = 3'd0;
  endtask

  task automatic do_load(input logic [2:0] c, input logic [11:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_chnl = c; ld_val = v;
    @(negedge clk);
    ld_en = 1'b0;
    m_ch[c] = v;
  endtask

  task automatic xfer(input logic [15:0] cmd, input int nbits, input int ld_at,
                      input logic [2:0] lc, input logic [11:0] lv, input int rst_at,
                      output logic [15:0] got_rx, output logic [15:0] exp_rx,
                      output int got_rdy, output int got_err,
                      output int exp_rdy, output int exp_err, output logic got_busy);
    logic [15:0] word;
    int rdy0, err0;
    word   = {4'h0, m_ch[m_chnl]};
    exp_rx = 16'h0000;
    for (int b = 0; b < nbits; b++)
      exp_rx = {exp_rx[14:0], (b < 16) ? word[4'(15 - b)] : 1'b0};
    rdy0 = rdy_cnt; err0 = err_cnt;
    got_rx = 16'h0000;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    got_busy = busy;
    for (int b = 0; b < nbits; b++) begin
      SCLK = 1'b0;
      MOSI = (b < 16) ? cmd[4'(15 - b)] : 1'b0;
      repeat (6) @(negedge clk);
      SCLK = 1'b1;
      got_rx = {got_rx[14:0], MISO};
      if (b == ld_at) begin
        ld_en = 1'b1; ld_chnl = lc; ld_val = lv;
        @(negedge clk);
        ld_en = 1'b0;
        repeat (5) @(negedge clk);
      end else if (b == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        snap_bus  = {MISO, cmd_rdy, frm_err, busy};
        snap_chnl = cmd_chnl;
        rst = 1'b0;
        repeat (5) @(negedge clk);
      end else begin
        repeat (6) @(negedge clk);
      end
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (10) @(negedge clk);
    got_rdy = rdy_cnt - rdy0;
    got_err = err_cnt - err0;
    if (ld_at >= 0 && ld_at < nbits) m_ch[lc] = lv;
    if (rst_at >= 0 && rst_at < nbits) begin
      model_reset();
      exp_rdy = 0; exp_err = 0;
    end else if (nbits == 16) begin
`ifdef A2D_RAMP_EN
      m_ch[m_chnl] = m_ch[m_chnl] + STEP;
`endif
      m_chnl = cmd[13:11];
      exp_rdy = 1; exp_err = 0;
    end else begin
      exp_rdy = 0; exp_err = 1;
    end
  endtask

  logic [15:0] g_rx, e_rx;
  int g_rdy, g_err, e_rdy, e_err;
  logic g_busy;

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({MISO, cmd_rdy, frm_err, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outs: got %b expected 0000", {MISO, cmd_rdy, frm_err, busy});
    end
    n_checks++;
    if (cmd_chnl !== 3'd0) begin
      n_fail++; $display("FAIL reset_chnl: got %0d expected 0", cmd_chnl);
    end
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    do_load(3'd3, 12'hABC);
    xfer(16'h1800, 16, -1, 3'd0, 12'h0, -1, g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
    n_checks++;
    if (g_rx !== e_rx) begin n_fail++; $display("FAIL basic_rx0: got %h expected %h", g_rx, e_rx); end
    n_checks++;
    if (g_rdy !== e_rdy || g_err !== e_err) begin
      n_fail++; $display("FAIL basic_pulses: got rdy %0d err %0d expected rdy %0d err %0d", g_rdy, g_err, e_rdy, e_err);
    end
    n_checks++;
    if (cmd_chnl !== m_chnl) begin n_fail++; $display("FAIL basic_chnl: got %0d expected %0d", cmd_chnl, m_chnl); end
    n_checks++;
    if (g_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", g_busy); end
    xfer(16'h0000, 16, -1, 3'd0, 12'h0, -1, g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
    n_checks++;
    if (g_rx !== e_rx) begin n_fail++; $display("FAIL basic_rx1: got %h expected %h", g_rx, e_rx); end
  endtask

  task automatic test_sequence();
    for (int n = 0; n < 8; n++) do_load(3'(n), 12'(12'h100 * n + n));
    for (int n = 0; n < 8; n++) begin
      xfer({2'b00, 3'(n), 11'h000}, 16, -1, 3'd0, 12'h0, -1, g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
      n_checks++;
      if (g_rx !== e_rx || g_err !== 0 || g_rdy !== 1) begin
        n_fail++; $display("FAIL seq_ch%0d: got rx %h err %0d rdy %0d expected rx %h err 0 rdy 1", n, g_rx, g_err, g_rdy, e_rx);
      end
    end
  endtask

  task automatic test_short_frame();
    logic [2:0] prev;
    prev = m_chnl;
    xfer(16'h3800, 12, -1, 3'd0, 12'h0, -1, g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
    n_checks++;
    if (g_err !== 1 || g_rdy !== 0) begin
      n_fail++; $display("FAIL short_pulses: got err %0d rdy %0d expected err 1 rdy 0", g_err, g_rdy);
    end
    n_checks++;
    if (cmd_chnl !== prev) begin n_fail++; $display("FAIL short_chnl: got %0d expected %0d", cmd_chnl, prev); end
    n_checks++;
    if (g_rx !== e_rx) begin n_fail++; $display("FAIL short_rx: got %h expected %h", g_rx, e_rx); end
    xfer(16'h3000, 16, -1, 3'd0, 12'h0, -1, g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
    n_checks++;
    if (g_rdy !== 1 || cmd_chnl !== 3'd6 || g_rx !== e_rx) begin
      n_fail++; $display("FAIL short_recover: got rdy %0d chnl %0d rx %h expected rdy 1 chnl 6 rx %h", g_rdy, cmd_chnl, g_rx, e_rx);
    end
    xfer(16'h0000, 0, -1, 3'd0, 12'h0, -1, g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
    n_checks++;
    if (g_err !== 1 || g_rdy !== 0) begin
      n_fail++; $display("FAIL zero_len: got err %0d rdy %0d expected err 1 rdy 0", g_err, g_rdy);
    end
  endtask

  task automatic test_rst_mid_frame();
    xfer(16'h2000, 16, -1, 3'd0, 12'h0, 7, g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
    n_checks++;
    if (snap_bus !== 4'b0000 || snap_chnl !== 3'd0) begin
      n_fail++; $display("FAIL rst_mid_outs: got %b chnl %0d expected 0000 chnl 0", snap_bus, snap_chnl);
    end
    n_checks++;
    if (g_rdy !== 0 || g_err !== 0) begin
      n_fail++; $display("FAIL rst_mid_pulses: got rdy %0d err %0d expected 0 0", g_rdy, g_err);
    end
    xfer(16'h2800, 16, -1, 3'd0, 12'h0, -1, g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
    n_checks++;
    if (cmd_chnl !== 3'd5 || g_rx !== e_rx) begin
      n_fail++; $display("FAIL rst_next: got chnl %0d rx %h expected chnl 5 rx %h", cmd_chnl, g_rx, e_rx);
    end
    xfer(16'h0000, 16, -1, 3'd0, 12'h0, -1, g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
    n_checks++;
    if (g_rx !== e_rx) begin n_fail++; $display("FAIL rst_chreg: got %h expected %h", g_rx, e_rx); end
  endtask

  task automatic test_midframe_load();
    do_load(3'd2, 12'h123);
    xfer(16'h1000, 16, -1, 3'd0, 12'h0, -1, g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
    xfer(16'h1000, 16, 5, 3'd2, 12'h555, -1, g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
    n_checks++;
    if (g_rx !== e_rx) begin n_fail++; $display("FAIL midload_old: got %h expected %h", g_rx, e_rx); end
    xfer(16'h0000, 16, -1, 3'd0, 12'h0, -1, g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
    n_checks++;
    if (g_rx !== e_rx) begin n_fail++; $display("FAIL midload_new: got %h expected %h", g_rx, e_rx); end
  endtask

  task automatic test_random();
    int lens [6] = '{16, 16, 16, 16, 12, 20};
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 1) == 1) do_load(3'($urandom_range(0, 7)), 12'($urandom));
      xfer(16'($urandom), lens[$urandom_range(0, 5)], -1, 3'd0, 12'h0, -1,
           g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
      n_checks++;
      if (g_rx !== e_rx || g_rdy !== e_rdy || g_err !== e_err || cmd_chnl !== m_chnl) begin
        n_fail++;
        $display("FAIL rand%0d: got rx %h rdy %0d err %0d chnl %0d expected rx %h rdy %0d err %0d chnl %0d",
                 it, g_rx, g_rdy, g_err, cmd_chnl, e_rx, e_rdy, e_err, m_chnl);
      end
    end
  endtask

`ifdef A2D_RAMP_EN
  task automatic test_ramp();
    do_load(3'd1, 12'hFFF);
    xfer(16'h0800, 16, -1, 3'd0, 12'h0, -1, g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
    xfer(16'h0800, 16, -1, 3'd0, 12'h0, -1, g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
    n_checks++;
    if (g_rx !== 16'h0FFF) begin n_fail++; $display("FAIL ramp_first: got %h expected 0fff", g_rx); end
    xfer(16'h0800, 16, -1, 3'd0, 12'h0, -1, g_rx, e_rx, g_rdy, g_err, e_rdy, e_err, g_busy);
    n_checks++;
    if (g_rx !== 16'h0000) begin n_fail++; $display("FAIL ramp_wrap: got %h expected 0000", g_rx); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_sequence();
    test_short_frame();
    test_rst_mid_frame();
    test_midframe_load();
    test_random();
`ifdef A2D_RAMP_EN
    test_ramp();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
